// File: rtl/score_display.sv
`timescale 1ns/1ps
// score_display
//   Converts a 14-bit binary score into four BCD digits using an iterative
//   shift-add-3 engine. It then scans those digits onto a multiplexed,
//   active-low, four-digit seven-segment display.
//
//   Optional feature macro: SCORE_DISPLAY_LZB_EN.
//   When it is defined, leading zeros are blanked by holding their anode off.
//   Digit 0 is always lit.
//
// Parameters
//   REFRESH_DIV : clock cycles each digit stays lit
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous, active-high reset
//   value  in   [13:0] binary score; values above 9999 display as 9999
//   blank  in   forces every anode off; conversion and scan keep running
//   bcd    out  [15:0] {thousands, hundreds, tens, ones}, registered
//   busy   out  high while the converter is outside IDLE
//   seg    out  [6:0] {g,f,e,d,c,b,a}, active-low, registered
//   an     out  [3:0] anode enables, active-low one-hot, registered
//   dp     out  decimal point, active-low, permanently off
module score_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        blank,
    output logic [15:0] bcd,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [3:0]    ITERATIONS   = 4'd14;

    conv_state_e state_q, state_d;
    logic [13:0] last_q, last_d;
    logic [13:0] op_q, op_d;
    logic [15:0] scratch_q, scratch_d;
    logic [3:0]  iter_q, iter_d;
    logic [15:0] bcd_q, bcd_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;

    logic [15:0] scratch_adj;
    logic [3:0]  digit_show;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    // A digit slot is shown when some digit at or above it is nonzero.
    // Slot 0 is always shown, so a score of zero still lights a single "0".
`ifdef SCORE_DISPLAY_LZB_EN
    always_comb begin
        digit_show[0] = 1'b1;
        digit_show[1] = |bcd_q[15:4];
        digit_show[2] = |bcd_q[15:8];
        digit_show[3] = |bcd_q[15:12];
    end
`else
    always_comb begin
        digit_show = 4'b1111;
    end
`endif

    always_comb begin
        // NOTE: every signal gets a default first; otherwise paths that skip an assignment infer latches.
        state_d     = state_q;
        last_d      = last_q;
        op_d        = op_q;
        scratch_d   = scratch_q;
        iter_d      = iter_q;
        bcd_d       = bcd_q;
        scratch_adj = scratch_q;

        // Add-3 correction: bump any BCD nibble of 5 or more before it doubles.
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                // Change detection uses the raw input.
                // A steady over-range value therefore converts only once.
                if (value != last_q) begin
                    last_d    = value;
                    op_d      = (value > 14'd9999) ? 14'd9999 : value;
                    scratch_d = '0;
                    iter_d    = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (iter_q == ITERATIONS) begin
                    state_d = DONE;
                end else begin
                    // Shift {scratch, operand} left by one bit, operand MSB first.
                    scratch_d = {scratch_adj[14:0], op_q[13]};
                    op_d      = {op_q[12:0], 1'b0};
                    iter_d    = iter_q + 4'd1;
                end
            end
            DONE: begin
                bcd_d   = scratch_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan path.
    // seg and an are both derived from the current index and registered together.
    always_comb begin
        refresh_d = (refresh_q == REFRESH_LAST) ? '0 : refresh_q + RW'(1);
        idx_d     = (refresh_q == REFRESH_LAST) ? idx_q + 2'd1 : idx_q;
        seg_d     = seg_decode(bcd_q[4*idx_q +: 4]);
        an_d      = 4'b1111;
        if (!blank && digit_show[idx_q]) begin
            an_d = ~(4'b0001 << idx_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= '0;
            op_q      <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            seg_q     <= 7'b1000000;
            an_q      <= 4'b1110;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            op_q      <= op_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = (state_q != IDLE);
    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_score_display.sv
`timescale 1ns/1ps
// tb_score_display
//   Directed bench for score_display, built with REFRESH_DIV = 4.
//   A decimal-level model predicts bcd, busy, an, seg and dp on every cycle.
//   Literal expectations pin the model at key points.
module tb_score_display;

    localparam int DIV = 4;
`ifdef SCORE_DISPLAY_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] value = '0;
    logic        blank = 1'b0;
    logic [15:0] bcd;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    score_display #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .blank (blank),
        .bcd   (bcd),
        .busy  (busy),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic int pow10(input int p);
        int r = 1;
        for (int i = 0; i < p; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    // Behavioural model.
    // m_val is the displayed decimal number.
    // A change accepted while idle takes effect 16 edges later.
    // The scan slot is (edges since reset / DIV) mod 4, and the outputs lag it by one edge.
    int          m_val, m_target, m_left, m_n;
    logic [13:0] m_last;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val = 0; m_target = 0; m_left = 0; m_n = 0;
            m_last = '0; m_an = 4'b1110; m_seg = 7'h40;
        end else begin : model_step
            int p;
            p = (m_n / DIV) % 4;
            if (blank || (LZB && p != 0 && m_val < pow10(p))) m_an = 4'b1111;
            else m_an = ~(4'b0001 << p);
            m_seg = seg_tab[(m_val / pow10(p)) % 10];
            m_n++;
            if (m_left == 0) begin
                if (value != m_last) begin
                    m_last   = value;
                    m_target = (int'(value) > 9999) ? 9999 : int'(value);
                    m_left   = 16;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_val = m_target;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, m_left != 0);
            check("bcd",  bcd,  to_bcd(m_val));
            check("an",   an,   m_an);
            check("seg",  seg,  m_seg);
            check("dp",   dp,   1'b1);
        end
    end

    task automatic wait_busy(input logic lvl, input string name);
        for (int i = 0; i < 100 && busy !== lvl; i++) @(negedge clk);
        check(name, busy, lvl);
    endtask

    logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    initial begin
        int cnt;
        int lit;
        logic [3:0] prev;

        // Reset state and quiet idle with value 0.
        repeat (3) @(negedge clk);
        check("rst_bcd",  bcd,  16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_an",   an,   4'b1110);
        check("rst_seg",  seg,  7'b1000000);
        check("rst_dp",   dp,   1'b1);
        rst = 1'b0;
        cnt = 0;
        repeat (20) begin @(negedge clk); if (busy) cnt++; end
        check("idle_no_busy", cnt, 0);
        check("idle_bcd", bcd, 16'h0000);

        // 1234: busy for exactly 16 cycles, then bcd = 0x1234.
        value = 14'd1234;
        cnt = 0;
        repeat (30) begin @(negedge clk); if (busy === 1'b1) cnt++; end
        check("busy_len", cnt, 16);
        check("bcd_1234", bcd, 16'h1234);

        // Scan: synchronise on the start of slot 0, then check a full frame.
        prev = an;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev != 4'b1110) break;
            prev = an;
        end
        check("scan_sync", an, 4'b1110);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < DIV; c++) begin
                check("scan_an",  an,  exp_an[d]);
                check("scan_seg", seg, exp_seg[d]);
                @(negedge clk);
            end
        end

        // Blank forces every anode off on the next update.
        blank = 1'b1;
        @(negedge clk);
        check("blank_an", an, 4'b1111);
        repeat (5) @(negedge clk);
        check("blank_an_hold", an, 4'b1111);
        blank = 1'b0;
        @(negedge clk);

        // Saturation and no retrigger while an over-range value is held.
        value = 14'd16383;
        wait_busy(1'b1, "sat1_start");
        wait_busy(1'b0, "sat1_end");
        check("sat_16383", bcd, 16'h9999);
        value = 14'd10000;
        wait_busy(1'b1, "sat2_start");
        wait_busy(1'b0, "sat2_end");
        check("sat_10000", bcd, 16'h9999);
        cnt = 0;
        repeat (40) begin @(negedge clk); if (busy) cnt++; end
        check("sat_hold_no_busy", cnt, 0);

        // 5 followed by 77 mid-conversion.
        value = 14'd5;
        repeat (3) @(negedge clk);
        value = 14'd77;
        wait_busy(1'b0, "mid_first_end");
        check("mid_bcd_5", bcd, 16'h0005);
        wait_busy(1'b1, "mid_second_start");
        wait_busy(1'b0, "mid_second_end");
        check("mid_bcd_77", bcd, 16'h0077);
        repeat (5) @(negedge clk);
        check("mid_settled", bcd, 16'h0077);

        // Value 7: with leading-zero blanking only slot 0 lights.
        value = 14'd7;
        wait_busy(1'b1, "lzb_start");
        wait_busy(1'b0, "lzb_end");
        check("lzb_bcd", bcd, 16'h0007);
        @(negedge clk);
        cnt = 0;
        lit = 0;
        repeat (4 * DIV) begin
            @(negedge clk);
            if (an == 4'b1111) cnt++;
            if (an == 4'b1110) lit++;
        end
        check("lzb_dark_slots", cnt, LZB ? 12 : 0);
        check("lzb_slot0_lit", lit, DIV);

        // Reset during shift iteration 7, then reconvert the held value.
        value = 14'd4321;
        wait_busy(1'b1, "abort_start");
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_bcd",  bcd,  16'h0000);
        check("abort_busy", busy, 1'b0);
        check("abort_an",   an,   4'b1110);
        check("abort_seg",  seg,  7'b1000000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_busy", busy, 1'b1);
        wait_busy(1'b0, "restart_end");
        check("restart_bcd", bcd, 16'h4321);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
